// File: rtl/reflet_float_sqrt_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reflet_float_sqrt_pkg : field sizes, bias, canonical NaN and FSM encodings |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package reflet_float_sqrt_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ITER  = 3'd1;
  localparam logic [2:0] S_ROUND = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_NORM  = 3'd4;

  function automatic int mantissa_size(input int fs);
    case (fs)
      16:      return 10;
      64:      return 52;
      default: return 23;
    endcase
  endfunction

  function automatic int exponent_size(input int fs);
    case (fs)
      16:      return 5;
      64:      return 11;
      default: return 8;
    endcase
  endfunction

  function automatic int bias(input int fs);
    return (1 << (exponent_size(fs) - 1)) - 1;
  endfunction

  // Positive quiet NaN: exponent all ones, only the mantissa MSB set.
  function automatic logic [63:0] canonical_nan(input int fs);
    int m;
    int e;
    m = mantissa_size(fs);
    e = exponent_size(fs);
    return (((64'd1 << e) - 64'd1) << m) | (64'd1 << (m - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/reflet_float_sqrt_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reflet_float_sqrt_step : one restoring square-root recurrence step         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module reflet_float_sqrt_step #(
  parameter int RW = 27,
  parameter int QW = 25
) (
  input  logic [RW-1:0] rem_i,
  input  logic [QW-1:0] root_i,
  input  logic [1:0]    bits_i,
  output logic [RW-1:0] rem_o,
  output logic [QW-1:0] root_o
);

  logic [RW+1:0] w_trial;
  logic [RW+1:0] w_sub;
  logic [RW+1:0] w_diff;
  logic          w_ge;
  logic          w_unused;

  // Trial subtraction of 4*root + 1 from the remainder extended by two radicand bits.
  assign w_trial = {rem_i, bits_i};
  assign w_sub   = {{(RW - QW){1'b0}}, root_i, 2'b01};
  assign w_ge    = (w_trial >= w_sub);
  assign w_diff  = w_trial - w_sub;

  assign rem_o  = w_ge ? w_diff[RW-1:0] : w_trial[RW-1:0];
  assign root_o = {root_i[QW-2:0], w_ge};

  assign w_unused = ^{w_trial[RW+1:RW], w_diff[RW+1:RW], root_i[QW-1]};

endmodule
`default_nettype wire

// File: rtl/reflet_float_sqrt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reflet_float_sqrt : sequential IEEE-754 square root, round-to-nearest-even |
// | Option macro REFLET_FLOAT_SQRT_SUBNORMAL_EN normalises subnormal operands  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module reflet_float_sqrt
  import reflet_float_sqrt_pkg::*;
#(
  parameter int FLOAT_SIZE = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [FLOAT_SIZE-1:0] in,
  output logic [FLOAT_SIZE-1:0] out,
  output logic                  ready,
  output logic                  invalid
);

  localparam int M    = mantissa_size(FLOAT_SIZE);
  localparam int EW   = exponent_size(FLOAT_SIZE);
  localparam int BIAS = bias(FLOAT_SIZE);
  localparam int QW   = M + 2;
  localparam int RW   = M + 4;
  localparam int RADW = 2 * QW;
  localparam int CW   = $clog2(QW);
  localparam int XW   = EW + 2;
  localparam logic [CW-1:0]         LAST_ITER = CW'(QW - 1);
  localparam logic [63:0]           QNAN64    = canonical_nan(FLOAT_SIZE);
  localparam logic [FLOAT_SIZE-1:0] QNAN      = QNAN64[FLOAT_SIZE-1:0];
`ifdef REFLET_FLOAT_SQRT_SUBNORMAL_EN
  localparam bit SUB_EN = 1'b1;
  localparam int LZW    = $clog2(M);
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [RADW-1:0]       rad_q, rad_d;
  logic [RW-1:0]         rem_q, rem_d;
  logic [QW-1:0]         root_q, root_d;
  logic [EW-1:0]         exp_q, exp_d;
  logic [FLOAT_SIZE-1:0] res_q, res_d;
  logic                  inv_q, inv_d;

  logic                  w_sign;
  logic [EW-1:0]         w_exp;
  logic [M-1:0]          w_mant;
  logic                  w_exp_ones, w_exp_zero, w_mant_zero;
  logic [M:0]            w_sig;
  logic signed [XW-1:0]  w_eunb, w_half, w_exp_sum;
  logic [QW-1:0]         w_rad;
  logic [RW-1:0]         w_rem_nx;
  logic [QW-1:0]         w_root_nx;
  logic                  w_up;
  logic [M:0]            w_mant_sum;
  logic [FLOAT_SIZE-1:0] w_round_res;
  logic                  w_unused;

  assign w_sign      = in[FLOAT_SIZE-1];
  assign w_exp       = in[FLOAT_SIZE-2 -: EW];
  assign w_mant      = in[M-1:0];
  assign w_exp_ones  = &w_exp;
  assign w_exp_zero  = ~|w_exp;
  assign w_mant_zero = ~|w_mant;

`ifdef REFLET_FLOAT_SQRT_SUBNORMAL_EN
  logic [M-1:0]   mant_q, mant_d;
  logic [LZW-1:0] w_lz;
  logic [M-1:0]   w_shift;
  logic           w_unused_sub;

  always_comb begin
    w_lz = '0;
    for (int i = 0; i < M; i++) begin
      if (mant_q[i]) w_lz = LZW'(M - 1 - i);
    end
  end
  assign w_shift      = mant_q << w_lz;
  assign w_unused_sub = w_shift[M-1];
`endif

  // Unpack: odd unbiased exponent moves one factor of two into the radicand.
  always_comb begin
    w_sig  = {1'b1, w_mant};
    w_eunb = XW'($signed({2'b00, w_exp}) - BIAS);
`ifdef REFLET_FLOAT_SQRT_SUBNORMAL_EN
    if (state_q == S_NORM) begin
      w_sig  = {1'b1, w_shift[M-2:0], 1'b0};
      w_eunb = XW'(-BIAS - int'(w_lz));
    end
`endif
  end

  assign w_rad     = w_eunb[0] ? {w_sig, 1'b0} : {1'b0, w_sig};
  assign w_half    = w_eunb >>> 1;
  assign w_exp_sum = w_half + XW'(BIAS);

  reflet_float_sqrt_step #(
    .RW (RW),
    .QW (QW)
  ) u_step (
    .rem_i  (rem_q),
    .root_i (root_q),
    .bits_i (rad_q[RADW-1 -: 2]),
    .rem_o  (w_rem_nx),
    .root_o (w_root_nx)
  );

  assign w_up        = root_q[0] & ((|rem_q) | root_q[1]);
  assign w_mant_sum  = {1'b0, root_q[M:1]} + (M + 1)'(w_up);
  assign w_round_res = {1'b0, exp_q + EW'(w_mant_sum[M]), w_mant_sum[M-1:0]};

  assign w_unused = ^{root_q[QW-1], w_exp_sum[XW-1:EW]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    exp_d   = exp_q;
    res_d   = res_q;
    inv_d   = inv_q;
`ifdef REFLET_FLOAT_SQRT_SUBNORMAL_EN
    mant_d  = mant_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          cnt_d  = '0;
          rem_d  = '0;
          root_d = '0;
          inv_d  = 1'b0;
          rad_d  = {w_rad, {QW{1'b0}}};
          exp_d  = w_exp_sum[EW-1:0];
          if (w_exp_ones && !w_mant_zero) begin
            res_d   = QNAN;
            inv_d   = 1'b1;
            state_d = S_DONE;
          end else if (w_exp_zero && (w_mant_zero || !SUB_EN)) begin
            res_d   = {w_sign, {(FLOAT_SIZE - 1){1'b0}}};
            state_d = S_DONE;
          end else if (w_sign) begin
            res_d   = QNAN;
            inv_d   = 1'b1;
            state_d = S_DONE;
          end else if (w_exp_ones) begin
            res_d   = {1'b0, {EW{1'b1}}, {M{1'b0}}};
            state_d = S_DONE;
`ifdef REFLET_FLOAT_SQRT_SUBNORMAL_EN
          end else if (w_exp_zero) begin
            mant_d  = w_mant;
            state_d = S_NORM;
`endif
          end else begin
            state_d = S_ITER;
          end
        end
      end
`ifdef REFLET_FLOAT_SQRT_SUBNORMAL_EN
      S_NORM: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else begin
          rad_d   = {w_rad, {QW{1'b0}}};
          exp_d   = w_exp_sum[EW-1:0];
          state_d = S_ITER;
        end
      end
`endif
      S_ITER: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else begin
          rem_d  = w_rem_nx;
          root_d = w_root_nx;
          rad_d  = rad_q << 2;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else begin
          res_d   = w_round_res;
          inv_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      exp_q   <= '0;
      res_q   <= '0;
      inv_q   <= 1'b0;
`ifdef REFLET_FLOAT_SQRT_SUBNORMAL_EN
      mant_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      exp_q   <= exp_d;
      res_q   <= res_d;
      inv_q   <= inv_d;
`ifdef REFLET_FLOAT_SQRT_SUBNORMAL_EN
      mant_q  <= mant_d;
`endif
    end
  end

  assign ready   = (state_q == S_DONE);
  assign out     = ready ? res_q : '0;
  assign invalid = ready & inv_q;

endmodule
`default_nettype wire

// File: tb/tb_reflet_float_sqrt.sv
`default_nettype none
// Directed bench for reflet_float_sqrt (FLOAT_SIZE=32) with an expected-result queue.
// Latency is counted in rising edges after the capture edge; specials finish on the capture edge.
module tb_reflet_float_sqrt;

  localparam int M = 23;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] in_v;
  logic [31:0] out_v;
  logic        ready;
  logic        invalid;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
    logic        inv;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  reflet_float_sqrt #(
    .FLOAT_SIZE (32)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .in      (in_v),
    .out     (out_v),
    .ready   (ready),
    .invalid (invalid)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic expect_op(input string tag, input logic [31:0] val, input logic inv, input int lat);
    exp_t e;
    e.tag = tag;
    e.val = val;
    e.inv = inv;
    e.lat = lat;
    sb.push_back(e);
  endtask

  // Raise enable with operand x, wait for ready, compare against the oldest queued expectation.
  task automatic run_op(input logic [31:0] x);
    int   cyc;
    exp_t e;
    @(negedge clk);
    in_v   = x;
    enable = 1'b1;
    cyc    = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 3) in_v = ~x;
    end while (!ready && cyc < 200);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_ready"}, 64'(ready), 64'd1);
      check({e.tag, "_latency"}, 64'(cyc - 1), 64'(e.lat));
      check({e.tag, "_out"}, 64'(out_v), 64'(e.val));
      check({e.tag, "_invalid"}, 64'(invalid), 64'(e.inv));
      @(negedge clk);
      check({e.tag, "_held_ready"}, 64'(ready), 64'd1);
      check({e.tag, "_held_out"}, 64'(out_v), 64'(e.val));
      enable = 1'b0;
      @(negedge clk);
      check({e.tag, "_drop_ready"}, 64'(ready), 64'd0);
      check({e.tag, "_drop_out"}, 64'(out_v), 64'd0);
    end
  endtask

  initial begin
    logic seen;
    reset  = 1'b1;
    enable = 1'b0;
    in_v   = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_out", 64'(out_v), 64'd0);
    check("reset_invalid", 64'(invalid), 64'd0);
    reset = 1'b0;

    expect_op("sqrt9", 32'h40400000, 1'b0, M + 3);
    run_op(32'h41100000);
    expect_op("sqrt2", 32'h3FB504F3, 1'b0, M + 3);
    run_op(32'h40000000);
    expect_op("sqrt4", 32'h40000000, 1'b0, M + 3);
    run_op(32'h40800000);
    expect_op("sqrt1", 32'h3F800000, 1'b0, M + 3);
    run_op(32'h3F800000);
    expect_op("below1", 32'h3F7FFFFF, 1'b0, M + 3);
    run_op(32'h3F7FFFFF);
    expect_op("maxnorm", 32'h5F7FFFFF, 1'b0, M + 3);
    run_op(32'h7F7FFFFF);
    expect_op("minnorm", 32'h20000000, 1'b0, M + 3);
    run_op(32'h00800000);

    expect_op("negzero", 32'h80000000, 1'b0, 0);
    run_op(32'h80000000);
    expect_op("poszero", 32'h00000000, 1'b0, 0);
    run_op(32'h00000000);
    expect_op("posinf", 32'h7F800000, 1'b0, 0);
    run_op(32'h7F800000);
    expect_op("negone", 32'h7FC00000, 1'b1, 0);
    run_op(32'hBF800000);
    expect_op("neginf", 32'h7FC00000, 1'b1, 0);
    run_op(32'hFF800000);
    expect_op("qnan", 32'h7FC00000, 1'b1, 0);
    run_op(32'h7FC00001);
    expect_op("negnan", 32'h7FC00000, 1'b1, 0);
    run_op(32'hFF812345);

`ifdef REFLET_FLOAT_SQRT_SUBNORMAL_EN
    expect_op("subnorm", 32'h1A3504F3, 1'b0, M + 4);
    run_op(32'h00000001);
    expect_op("negsub", 32'h7FC00000, 1'b1, 0);
    run_op(32'h80000001);
`else
    expect_op("subnorm", 32'h00000000, 1'b0, 0);
    run_op(32'h00000001);
    expect_op("negsub", 32'h80000000, 1'b0, 0);
    run_op(32'h80000001);
`endif

    // Abort 4.0 after 10 cycles; the re-enabled 16.0 must start from IDLE.
    @(negedge clk);
    in_v   = 32'h40800000;
    enable = 1'b1;
    seen   = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen |= ready;
    end
    enable = 1'b0;
    check("abort_no_ready", 64'(seen), 64'd0);
    expect_op("sqrt16", 32'h40800000, 1'b0, M + 3);
    run_op(32'h41800000);

    // Reset in the middle of 9.0 with enable still high.
    @(negedge clk);
    in_v   = 32'h41100000;
    enable = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_ready", 64'(ready), 64'd0);
    check("midreset_out", 64'(out_v), 64'd0);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen |= ready;
    end
    check("midreset_no_ready", 64'(seen), 64'd0);
    expect_op("after_reset", 32'h40400000, 1'b0, M + 3);
    run_op(32'h41100000);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
